// File: rtl/rmt_alu_pkg.sv
// Shared opcode and action-field definitions for the stateful ALU.
// Imported by stateful_alu and stateful_alu_mem.
package rmt_alu_pkg;

    localparam int OPC_W   = 4;
    localparam int IMM_W   = 16;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_STORE = 4'b1000;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'b1011;
    localparam logic [OPC_W-1:0] OP_LADD  = 4'b1100;

endpackage

// File: rtl/stateful_alu_mem.sv
// State memory: DEPTH x WIDTH register array, async clear, one write port,
// one read port (raddr -> rdata) that returns same-cycle write data first.
module stateful_alu_mem
    import rmt_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-first: a reader at the writing edge sees the new value.
    assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/stateful_alu.sv
// Two-stage stateful ALU for one container slot; define STATEFUL_ALU_SAT_EN
// for saturating arithmetic. Ports: clk, rst_n, action/operands in, container out.
module stateful_alu
    import rmt_alu_pkg::*;
#(
    parameter int STAGE      = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    input  logic [DATA_WIDTH-1:0] operand_3_in,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_valid
);

    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

    typedef logic [DATA_WIDTH-1:0] data_t;

    function automatic data_t f_add(input data_t a, input data_t b);
`ifdef STATEFUL_ALU_SAT_EN
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_WIDTH] ? '1 : s[DATA_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic data_t f_sub(input data_t a, input data_t b);
`ifdef STATEFUL_ALU_SAT_EN
        return (b > a) ? '0 : a - b;
`else
        return a - b;
`endif
    endfunction

    logic [OPC_W-1:0]      opc;
    logic [IMM_W-1:0]      imm16;
    logic [ADDR_WIDTH-1:0] addr;

    assign opc   = action_in[ACTION_LEN-1 -: OPC_W];
    assign imm16 = action_in[IMM_LSB +: IMM_W];
    assign addr  = imm16[ADDR_WIDTH-1:0];

    logic unused;
    assign unused = ^{operand_3_in, action_in, 1'(STAGE)};

    logic                  s1_valid;
    logic [OPC_W-1:0]      s1_opc;
    data_t                 s1_op1;
    data_t                 s1_op2;
    data_t                 s1_imm;
    data_t                 s1_mem;
    logic [ADDR_WIDTH-1:0] s1_addr;

    logic  wr_en;
    data_t res;
    data_t rd_data;

    stateful_alu_mem #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (s1_addr),
        .wdata (res),
        .raddr (addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_opc   <= '0;
            s1_op1   <= '0;
            s1_op2   <= '0;
            s1_imm   <= '0;
            s1_mem   <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= action_valid;
            s1_opc   <= opc;
            s1_op1   <= operand_1_in;
            s1_op2   <= operand_2_in;
            s1_imm   <= DATA_WIDTH'(imm16);
            s1_mem   <= rd_data;
            s1_addr  <= addr;
        end
    end

    logic is_add, is_sub, is_addi;
    logic is_store, is_load, is_ladd;

    assign is_add   = (s1_opc == OP_ADD);
    assign is_sub   = (s1_opc == OP_SUB);
    assign is_addi  = (s1_opc == OP_ADDI);
    assign is_store = (s1_opc == OP_STORE);
    assign is_load  = (s1_opc == OP_LOAD);
    assign is_ladd  = (s1_opc == OP_LADD);

    always_comb begin
        res   = s1_op1;
        wr_en = 1'b0;
        unique case (1'b1)
            is_add:   res = f_add(s1_op1, s1_op2);
            is_sub:   res = f_sub(s1_op1, s1_op2);
            is_addi:  res = f_add(s1_op1, s1_imm);
            is_store: begin
                res   = s1_op1;
                wr_en = s1_valid;
            end
            is_load:  res = s1_mem;
            is_ladd:  begin
                res   = f_add(s1_mem, s1_op2);
                wr_en = s1_valid;
            end
            default:  res = s1_op1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            container_out       <= '0;
            container_out_valid <= 1'b0;
        end else begin
            container_out_valid <= s1_valid;
            if (s1_valid) begin
                container_out <= res;
            end
        end
    end

endmodule
